// File: rtl/rr_arb_mux_if.sv
// Bundle of the arbitrated-mux handshake signals: N producer channels on the
// input side and a single consumer on the output side. The producer/consumer
// environment takes the master modport; the arbiter takes the slave modport.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);

  logic                 Mode;
  logic [N-1:0]         InValid;
  logic [N*WIDTH-1:0]   InData;
  logic [N-1:0]         InReady;
  logic                 OutValid;
  logic [WIDTH-1:0]     OutData;
  logic [SELW-1:0]      OutSlt;
  logic                 OutReady;

  modport master (
    output Mode,
    output InValid,
    output InData,
    output OutReady,
    input  InReady,
    input  OutValid,
    input  OutData,
    input  OutSlt
  );

  modport slave (
    input  Mode,
    input  InValid,
    input  InData,
    input  OutReady,
    output InReady,
    output OutValid,
    output OutData,
    output OutSlt
  );

endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer with a single registered output word.
// Grant policy is round-robin (Mode=0, scan starts at ptr_q) or fixed
// priority (Mode=1, channel 0 highest). The output register refills in the
// same cycle it drains, so a steady stream moves one word per cycle.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic         clk,
  input  logic         reset,
  rr_arb_mux_if.slave  bus
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_slt_q,   out_slt_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;

  logic                accept;
  logic [SELW-1:0]     scan_start;
  logic                grant_vld;
  logic [SELW-1:0]     grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic                xfer_in;

  // The register can take a word when it is empty or being drained now;
  // this keeps the OutReady->InReady path combinational.
  assign accept     = !out_valid_q || bus.OutReady;
  assign scan_start = bus.Mode ? '0 : ptr_q;

  // Pick the valid channel with the smallest cyclic distance from the scan
  // start; fixed priority is simply a scan that always starts at channel 0.
  always_comb begin
    int d;
    int best_d;
    d          = 0;
    best_d     = N;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(scan_start);
      if (d < 0) d = d + N;
      if (bus.InValid[i] && (d < best_d)) begin
        best_d     = d;
        grant_vld  = 1'b1;
        grant_idx  = SELW'(i);
        grant_data = bus.InData[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the granted channel sees ready, and only when the register can accept.
  always_comb begin
    bus.InReady = '0;
    for (int i = 0; i < N; i++) begin
      bus.InReady[i] = grant_vld && accept && (grant_idx == SELW'(i));
    end
  end

  assign xfer_in = grant_vld && accept;

  // Next state: load on input transfer (overwrites a draining word, no
  // bubble), clear valid on a plain drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_slt_d   = out_slt_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_slt_d   = grant_idx;
      if (!bus.Mode) begin
        // Wrap at N, not 2**SELW, so out-of-range pointers never appear.
        ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_valid_q && bus.OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_slt_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_slt_q   <= out_slt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.OutValid = out_valid_q;
  assign bus.OutData  = out_data_q;
  assign bus.OutSlt   = out_slt_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel 32-bit instance for the main
// scenarios and a 3-channel 8-bit instance for pointer wrap at N.
module tb_rr_arb_mux;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  rr_arb_mux_if #(.WIDTH(32), .N(4), .SELW(2)) ifa ();
  rr_arb_mux_if #(.WIDTH(8),  .N(3), .SELW(2)) ifb ();

  rr_arb_mux #(.WIDTH(32), .N(4), .SELW(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  rr_arb_mux #(.WIDTH(8), .N(3), .SELW(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b1;
    ifa.Mode     = 1'b0;
    ifa.InValid  = '0;
    ifa.InData   = '0;
    ifa.OutReady = 1'b0;
    ifb.Mode     = 1'b0;
    ifb.InValid  = '0;
    ifb.InData   = '0;
    ifb.OutReady = 1'b0;

    // Reset then idle
    step();
    step();
    chk("rst_vld",   ifa.OutValid, 1'b0);
    chk("rst_data",  ifa.OutData,  32'h0);
    chk("rst_slt",   ifa.OutSlt,   2'd0);
    chk("rst_rdy",   ifa.InReady,  4'b0000);
    reset = 1'b0;
    step();
    chk("idle_vld",  ifa.OutValid, 1'b0);
    chk("idle_rdy",  ifa.InReady,  4'b0000);
    chk("b_idle_vld", ifb.OutValid, 1'b0);

    // Round-robin fairness with all four channels requesting
    for (int i = 0; i < 4; i++) ifa.InData[i*32 +: 32] = 32'hA0 + i;
    ifa.InValid  = 4'b1111;
    ifa.OutReady = 1'b1;
    #1;
    chk("rr_rdy0", ifa.InReady, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_vld",  ifa.OutValid, 1'b1);
      chk("rr_slt",  ifa.OutSlt,   k % 4);
      chk("rr_data", ifa.OutData,  32'hA0 + (k % 4));
      chk("rr_rdy",  ifa.InReady,  4'b0001 << ((k + 1) % 4));
    end

    // Fixed priority: channel 1 wins every cycle over 2 and 3
    ifa.Mode    = 1'b1;
    ifa.InValid = 4'b1110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fp_rdy", ifa.InReady, 4'b0010);
      step();
      chk("fp_slt",  ifa.OutSlt,  2'd1);
      chk("fp_data", ifa.OutData, 32'hA1);
    end

    // Drain, then one word from ch2 held under backpressure
    ifa.InValid = 4'b0000;
    step();
    chk("drain_vld", ifa.OutValid, 1'b0);
    ifa.Mode     = 1'b0;
    ifa.InValid  = 4'b0100;
    ifa.InData[2*32 +: 32] = 32'hDEAD_BEEF;
    ifa.OutReady = 1'b0;
    #1;
    chk("bp_rdy_in", ifa.InReady, 4'b0100);
    step();
    ifa.InData[2*32 +: 32] = 32'h1234_5678;
    ifa.InValid = 4'b1011;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_vld",  ifa.OutValid, 1'b1);
      chk("bp_data", ifa.OutData,  32'hDEAD_BEEF);
      chk("bp_slt",  ifa.OutSlt,   2'd2);
      chk("bp_rdy",  ifa.InReady,  4'b0000);
      step();
    end
    // Ptr is 3 after the ch2 grant; releasing OutReady grants ch3 at once
    ifa.OutReady = 1'b1;
    #1;
    chk("bp_rel_rdy", ifa.InReady, 4'b1000);
    step();
    chk("bp_next_vld",  ifa.OutValid, 1'b1);
    chk("bp_next_slt",  ifa.OutSlt,   2'd3);
    chk("bp_next_data", ifa.OutData,  32'hA3);

    // Reset in the middle of a stream
    ifa.InValid = 4'b1111;
    step();
    chk("mid_slt", ifa.OutSlt, 2'd0);
    chk("mid_vld", ifa.OutValid, 1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_vld",  ifa.OutValid, 1'b0);
    chk("mid_rst_data", ifa.OutData,  32'h0);
    chk("mid_rst_slt",  ifa.OutSlt,   2'd0);
    reset = 1'b0;
    #1;
    chk("mid_rel_rdy", ifa.InReady, 4'b0001);
    step();
    chk("mid_rel_slt",  ifa.OutSlt,  2'd0);
    chk("mid_rel_data", ifa.OutData, 32'hA0);
    ifa.InValid = 4'b0000;

    // Pointer wrap at N=3
    for (int i = 0; i < 3; i++) ifb.InData[i*8 +: 8] = 8'h10 + i;
    ifb.OutReady = 1'b1;
    ifb.InValid  = 3'b100;
    #1;
    chk("w_rdy2", ifb.InReady, 3'b100);
    step();
    chk("w_slt2",  ifb.OutSlt,  2'd2);
    chk("w_data2", ifb.OutData, 8'h12);
    ifb.InValid = 3'b011;
    #1;
    chk("w_rdy0", ifb.InReady, 3'b001);
    step();
    chk("w_slt0", ifb.OutSlt, 2'd0);
    #1;
    chk("w_rdy1", ifb.InReady, 3'b010);
    step();
    chk("w_slt1", ifb.OutSlt, 2'd1);
    ifb.InValid = 3'b101;
    #1;
    chk("w_rdy2b", ifb.InReady, 3'b100);
    step();
    chk("w_slt2b", ifb.OutSlt, 2'd2);
    #1;
    chk("w_rdy0b", ifb.InReady, 3'b001);
    step();
    chk("w_slt0b",  ifb.OutSlt,  2'd0);
    chk("w_data0b", ifb.OutData, 8'h10);
    ifb.InValid = 3'b000;
    step();
    chk("w_end_vld", ifb.OutValid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It replaces fixed-select operand/source muxes wherever several producers compete for one consumer, e.g. the bridge path where CPU, CP0 and peripheral requests share one bus port. Grant policy is run-time selectable between round-robin and fixed priority. The output holds one word and sustains one transfer per cycle.

## Interface
- WIDTH, 32, data width per channel (1..64)
- N, 4, channel count (2..8)
- SELW, 2, width of channel index; N <= 2**SELW required
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
- InValid  input  N  per-channel request valid
- InData  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- InReady  output  N  per-channel accept, combinational, at most one bit set
- OutValid  output  1  registered word valid
- OutData  output  WIDTH  registered data of granted channel
- OutSlt  output  SELW  registered index of the channel that supplied OutData
- OutReady  input  1  consumer accept

## Operation
- Internal state: Ptr (SELW bits, RR start index), output register {OutValid, OutData, OutSlt}.
- Accept = !OutValid || OutReady (output empty or draining this cycle).
- Grant g (combinational): Mode=0 → first i with InValid[i]=1 scanning Ptr, Ptr+1, … cyclically mod N; Mode=1 → lowest i with InValid[i]=1. No valid channel → no grant.
- InReady[g] = Accept when a grant exists; all other InReady bits 0. InReady never depends on InValid of the granted channel beyond the scan.
- Input transfer on channel g: InValid[g] && InReady[g]. On it: OutData ← InData[g], OutSlt ← g, OutValid ← 1.
- Output transfer: OutValid && OutReady. If no input transfer in the same cycle, OutValid ← 0; OutData/OutSlt keep their value.
- Simultaneous output and input transfer: register is overwritten with the new word, OutValid stays 1 (no bubble).
- Ptr update: Mode=0 and input transfer → Ptr ← (g == N-1) ? 0 : g+1 (wrap at N, not 2**SELW). Mode=1 → Ptr unchanged. No transfer → Ptr unchanged.
- Mode may change any cycle; new policy applies to the grant in that same cycle.
- Ptr values ≥ N never occur.

## Timing
- Reset values: OutValid=0, OutData=0, OutSlt=0, Ptr=0; InReady follows combinationally (Accept=1 after reset).
- Latency: input transfer in cycle t → OutValid=1 with that data in cycle t+1.
- Throughput: one word per cycle with OutReady held high.
- While OutValid=1 and OutReady=0: OutData, OutSlt stable, all InReady=0.
- Producer InData need not be held after its transfer cycle.
- Reset asserted mid-operation: held word discarded, Ptr returns to 0 at the next edge regardless of OutReady/InValid.
- No combinational path from InValid to OutValid; OutReady→InReady path is combinational.

## Test plan
- Reset then idle: reset=1 two cycles, InValid=0 → OutValid=0, OutData=0, OutSlt=0, InReady=4'b1111-masked-to-none (all 0).
- RR fairness: N=4, Mode=0, InValid=4'b1111 held, OutReady=1, InData[i]=32'hA0+i → OutSlt sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Fixed priority: Mode=1, InValid=4'b1110, OutReady=1 for 4 cycles → OutSlt=1 every cycle, channels 2,3 never get InReady.
- Backpressure: single word from ch2 (32'hDEAD_BEEF), OutReady=0 for 3 cycles → OutValid=1, OutData=32'hDEADBEEF, OutSlt=2 stable, InReady=0; OutReady=1 → word consumed, next grant same cycle.
- Wrap with N=3, SELW=2: Mode=0, only ch2 valid once, then InValid=3'b011 → after ch2 grant Ptr=0, next grant ch0 (never index 3).
- Reset mid-stream: during RR stream with OutValid=1, assert reset one cycle → next cycle OutValid=0, Ptr=0; first grant after release with all valid is ch0.
